fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter for the async FIFO memory, in the write-clock domain. It shares the single FIFO write port (winc/wdata, gated by wfull) among NREQ requesters. Each grant is a burst of up to MAXBURST beats, with per-requester valid/ready handshakes. It sits between the write-side producers and the FIFO write-pointer/full logic.

## Interface
- DATASIZE, 8, data word width (must match the FIFO memory width)
- NREQ, 4, number of requesters (>= 2)
- MAXBURST, 4, maximum beats per grant (>= 1)
- wclk  in  1  write-domain clock, rising edge
- wrst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester data valid
- req_last  in  NREQ  per-requester "last beat of burst"; sampled only on an accepted beat
- req_data  in  NREQ*DATASIZE  requester i occupies bits [i*DATASIZE +: DATASIZE]
- req_ready  out  NREQ  per-requester accept; at most one bit high
- wfull  in  1  FIFO full flag from the write-side full logic
- winc  out  1  FIFO write enable, one word per high cycle
- wdata  out  DATASIZE  FIFO write data
- owner  out  $clog2(NREQ)  index of the current grant holder
- busy  out  1  high while in BURST

## Operation
- State machine has two states: IDLE and BURST. Registers: state, owner, rr_ptr ($clog2(NREQ)), beat_cnt ($clog2(MAXBURST+1)).
- IDLE:
  - If any req_valid is high, owner <= first index i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod NREQ.
  - Also beat_cnt <= 0 and state <= BURST.
  - No beats are accepted in IDLE.
- BURST:
  - req_ready[owner] = !wfull; all other req_ready bits = 0.
  - beat = req_valid[owner] && req_ready[owner].
  - winc = beat; wdata = req_data[owner] (combinational).
  - Each beat increments beat_cnt.
- Burst end:
  - Triggered by a beat with req_last[owner]=1, or a beat that makes beat_cnt == MAXBURST.
  - On that edge: state <= IDLE, rr_ptr <= (owner+1) mod NREQ.
- Owner drops valid mid-burst: the grant is held indefinitely and no other requester is served. Producers must complete bursts.
- wfull high: no beat occurs and the grant is held. beat_cnt and the state are unchanged.
- winc is never high when wfull is high; the FIFO sees no write attempts while full.
- Non-owner requesters may assert and deassert valid freely; they only affect the next arbitration.
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
  - Outputs: winc=0, req_ready=0, busy=0, wdata=req_data[0] (don't-care).
  - A partially accepted burst is abandoned.

## Timing
- Arbitration latency: the first beat can occur on the cycle after the IDLE cycle that sees valid. Minimum 1 cycle from valid to ready.
- Peak throughput: MAXBURST beats per MAXBURST+1 cycles, because there is one IDLE bubble between grants.
- winc/wdata are combinational from the BURST state and inputs. The FIFO captures on the same wclk edge as the handshake.
- wfull is used as-is, with no added registering; the full logic already provides it synchronously to wclk.

## Configuration
- Macro: WARB_STATS_EN.
- Defined:
  - Adds input stat_clr (1) and output stat_beats (NREQ*16).
  - Requester i's count is in [i*16 +: 16]: a saturating count of accepted beats, held at 16'hFFFF.
  - stat_clr clears all counters synchronously. If stat_clr and a beat occur in the same cycle, the result is 0.
  - Counters reset to 0 on wrst_n.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical.

## Test plan
- Single requester, burst length: reset, then req_valid=4'b0100 with 6 words and no last → expected sequence:
  - beats 1–4: owner=2, winc high;
  - IDLE bubble;
  - regrant to 2 for the remaining 2 words;
  - wdata matches input order.
- Round-robin order: all four valid, each with a 1-beat burst (last=1) → grant order 0,1,2,3,0 with one bubble between grants.
- Full stall: mid-burst, hold wfull=1 for 5 cycles → winc=0, req_ready=0 and owner is unchanged. The burst resumes and beat_cnt completes at MAXBURST.
- Early last: requester 1 sends 2 beats with last on beat 2 → returns to IDLE, next grant starts its search at requester 2.
- Reset mid-burst: assert wrst_n=0 after beat 2 → winc, req_ready and busy drop immediately. After release, the grant order starts from requester 0.
- With WARB_STATS_EN defined:
  - 3 beats from requester 3 → stat_beats[63:48]=3;
  - pulse stat_clr → 0;
  - forcing a counter to 16'hFFFE then sending 3 beats → 16'hFFFF.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ bursting producers.
// Optional per-requester beat counters are compiled in with WARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int DATASIZE = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                       wclk,
  input  logic                       wrst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_last,
  input  logic [NREQ*DATASIZE-1:0]   req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       wfull,
  output logic                       winc,
  output logic [DATASIZE-1:0]        wdata,
  output logic [$clog2(NREQ)-1:0]    owner,
  output logic                       busy
`ifdef WARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [NREQ*16-1:0]         stat_beats
`endif
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] pick;
  logic          any_valid;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_nxt;
  logic          beat;
  logic          burst_end;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    pick      = rr_ptr;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_valid && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        any_valid = 1'b1;
        pick      = OW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready        = '0;
    req_ready[owner] = (state == BURST) && !wfull;
  end

  assign busy      = (state == BURST);
  assign beat      = req_ready[owner] && req_valid[owner];
  assign winc      = beat;
  assign wdata     = req_data[owner*DATASIZE +: DATASIZE];
  assign beat_nxt  = beat_cnt + 1'b1;
  assign burst_end = beat && (req_last[owner] || (beat_nxt == CW'(MAXBURST)));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = BURST;
      BURST:   if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (any_valid) begin
        owner    <= pick;
        beat_cnt <= '0;
      end
    end else if (beat) begin
      beat_cnt <= beat_nxt;
      if (burst_end) rr_ptr <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end
  end

`ifdef WARB_STATS_EN
  // Saturating accepted-beat counters; clear wins over a simultaneous beat
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n)                                        cnt <= '0;
      else if (stat_clr)                                  cnt <= '0;
      else if (beat && owner == OW'(i) && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign stat_beats[i*16 +: 16] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: burst length, round-robin order, full stall,
// early last, reset mid-burst, and (with WARB_STATS_EN) the beat counters.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  owner;
  logic        busy;
`ifdef WARB_STATS_EN
  logic        stat_clr;
  logic [63:0] stat_beats;
`endif

  int checks   = 0;
  int failures = 0;

  fifo_wr_arbiter #(.DATASIZE(8), .NREQ(4), .MAXBURST(4)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .owner     (owner),
    .busy      (busy)
`ifdef WARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_beats(stat_beats)
`endif
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #2;
  endtask

  task automatic set_word(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    wrst_n    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
`ifdef WARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    step();
    step();
    wrst_n = 1'b1;
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] o, input logic [7:0] d);
    #1;
    chk({tag, "_winc"}, {31'd0, winc}, 32'd1);
    chk({tag, "_owner"}, {30'd0, owner}, {30'd0, o});
    chk({tag, "_wdata"}, {24'd0, wdata}, {24'd0, d});
    chk({tag, "_ready"}, {28'd0, req_ready}, {28'd0, 4'b0001 << o});
  endtask

  initial begin
    // Reset state
    do_reset();
    wrst_n = 1'b0;
    #1;
    chk("rst_winc",  {31'd0, winc}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    wrst_n = 1'b1;

    // Single requester 2, six words, no last
    req_valid = 4'b0100;
    set_word(2, 8'hA0);
    #1;
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_idle_winc", {31'd0, winc}, 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      set_word(2, 8'hA0 + 8'(k));
      chk_beat("t1_b", 2'd2, 8'hA0 + 8'(k));
      step();
    end
    set_word(2, 8'hA4);
    #1;
    chk("t1_bubble_busy", {31'd0, busy}, 32'd0);
    chk("t1_bubble_winc", {31'd0, winc}, 32'd0);
    step();
    for (int k = 4; k < 6; k++) begin
      set_word(2, 8'hA0 + 8'(k));
      chk_beat("t1_r", 2'd2, 8'hA0 + 8'(k));
      step();
    end
    req_valid = '0;
    #1;
    chk("t1_hold_busy", {31'd0, busy}, 32'd1);
    chk("t1_hold_winc", {31'd0, winc}, 32'd0);

    // Round-robin, all valid, 1-beat bursts
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = 32'h13121110;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("rr_bubble", {31'd0, busy}, 32'd0);
      step();
      chk_beat("rr", 2'(g % 4), 8'h10 + 8'(g % 4));
      step();
    end

    // Full stall mid-burst
    do_reset();
    req_valid = 4'b0001;
    set_word(0, 8'h55);
    step();
    chk_beat("st_b1", 2'd0, 8'h55);
    step();
    chk_beat("st_b2", 2'd0, 8'h55);
    step();
    wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("st_winc",  {31'd0, winc}, 32'd0);
      chk("st_ready", {28'd0, req_ready}, 32'd0);
      chk("st_owner", {30'd0, owner}, 32'd0);
      chk("st_busy",  {31'd0, busy}, 32'd1);
      step();
    end
    wfull = 1'b0;
    chk_beat("st_b3", 2'd0, 8'h55);
    step();
    chk_beat("st_b4", 2'd0, 8'h55);
    step();
    #1;
    chk("st_done_busy", {31'd0, busy}, 32'd0);

    // Early last from requester 1; next search starts at 2
    do_reset();
    req_valid = 4'b0010;
    set_word(1, 8'h21);
    step();
    chk_beat("el_b1", 2'd1, 8'h21);
    step();
    req_last = 4'b0010;
    chk_beat("el_b2", 2'd1, 8'h21);
    step();
    req_last  = '0;
    req_valid = 4'b1011;
    #1;
    chk("el_idle_busy", {31'd0, busy}, 32'd0);
    step();
    #1;
    chk("el_next_owner", {30'd0, owner}, 32'd3);

    // Reset mid-burst restarts the round-robin at requester 0
    do_reset();
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    step();
    chk_beat("rm_first", 2'd2, 8'h00);
    step();
    req_last = '0;
    step();
    chk_beat("rm_b1", 2'd2, 8'h00);
    step();
    chk_beat("rm_b2", 2'd2, 8'h00);
    step();
    wrst_n = 1'b0;
    #1;
    chk("rm_winc",  {31'd0, winc}, 32'd0);
    chk("rm_ready", {28'd0, req_ready}, 32'd0);
    chk("rm_busy",  {31'd0, busy}, 32'd0);
    step();
    wrst_n    = 1'b1;
    req_valid = 4'b1111;
    step();
    #1;
    chk("rm_owner", {30'd0, owner}, 32'd0);

`ifdef WARB_STATS_EN
    // Beat counters
    do_reset();
    req_valid = 4'b1000;
    step();
    step();
    step();
    req_last = 4'b1000;
    step();
    req_valid = '0;
    req_last  = '0;
    #1;
    chk("stat_r3", {16'd0, stat_beats[63:48]}, 32'd3);
    chk("stat_r0", {16'd0, stat_beats[15:0]}, 32'd0);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    #1;
    chk("stat_clr", {16'd0, stat_beats[63:48]}, 32'd0);
    req_valid = 4'b1000;
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    #1;
    chk("stat_clr_beat", {16'd0, stat_beats[63:48]}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
